// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit engine.
// Frame geometry and the word-select rule live here.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DW_DFLT    = 16;
  localparam int FRAME_BITS = 2 * DW_DFLT;
  localparam int SLOT_W     = $clog2(FRAME_BITS);

  // ws level while slot k is on the wire: flips one slot ahead of the MSB
  function automatic logic ws_of(
    input int unsigned k,
    input int unsigned dw
  );
    return ((k + 1) % (2 * dw)) >= dw;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// SCK generator: owns the SCK level and flags the edge that toggles it.
// Counter storage stays in the top so it can be reset at frame load.
module i2s_clk_div
  import i2s_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] cnt,
  input  logic [DIV_W-1:0] div_lat,
  input  logic             run,
  output logic             sck,
  output logic             rise_tick,
  output logic             fall_tick
);

  logic wrap;

  assign wrap      = run && (cnt == div_lat);
  assign rise_tick = wrap && !sck;
  assign fall_tick = wrap && sck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck <= 1'b0;
    end else if (!run) begin
      sck <= 1'b0;
    end else if (wrap) begin
      sck <= !sck;
    end
  end

endmodule

// File: rtl/i2s_tx_core.sv
// Philips I2S transmitter: holding register, frame shifter, slot counter.
// SCK timing comes from i2s_clk_div; WS/SD move only on falling toggles.
module i2s_tx_core
  import i2s_pkg::*;
#(
  parameter int DW    = DW_DFLT,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [2*DW-1:0]   s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              i2s_sck,
  output logic              i2s_ws,
  output logic              i2s_sd,
  output logic              busy,
  output logic              underrun
);

  localparam int FB = 2 * DW;
  localparam int SW = $clog2(FB);

  state_t           state;
  logic [FB-1:0]    hold;
  logic             hold_valid;
  logic [FB-1:0]    shifter;
  logic [SW-1:0]    slot;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] div_cnt;
  logic             rise_tick;
  logic             fall_tick;

  assign s_ready = !hold_valid;
  assign busy    = (state == RUN);

  i2s_clk_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .cnt       (div_cnt),
    .div_lat   (div_lat),
    .run       (busy),
    .sck       (i2s_sck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      shifter    <= '0;
      slot       <= '0;
      div_lat    <= '0;
      div_cnt    <= '0;
      i2s_ws     <= 1'b0;
      i2s_sd     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (s_valid && !hold_valid) begin
        hold       <= s_data;
        hold_valid <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (enable && hold_valid) begin
            state      <= RUN;
            shifter    <= hold;
            hold_valid <= 1'b0;
            div_lat    <= clk_div;
            div_cnt    <= '0;
            slot       <= '0;
            i2s_ws     <= 1'b0;
            i2s_sd     <= hold[FB-1];
          end
        end
        RUN: begin
          if (rise_tick || fall_tick) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (fall_tick) begin
            if (slot == SW'(FB - 1)) begin
              // frame boundary: reload, pad with silence, or stop
              slot    <= '0;
              div_lat <= clk_div;
              i2s_ws  <= 1'b0;
              if (!enable) begin
                state   <= IDLE;
                shifter <= '0;
                i2s_sd  <= 1'b0;
              end else if (hold_valid) begin
                shifter    <= hold;
                hold_valid <= 1'b0;
                i2s_sd     <= hold[FB-1];
              end else begin
                shifter  <= '0;
                i2s_sd   <= 1'b0;
                underrun <= 1'b1;
              end
            end else begin
              slot    <= slot + 1'b1;
              shifter <= shifter << 1;
              i2s_sd  <= shifter[FB-2];
              i2s_ws  <= ws_of(32'(slot) + 32'd1, DW);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_core.sv
// Directed bench for i2s_tx_core: table of frame vectors plus
// hand sequences for abort, divider change, reset and gated enable.
module tb_i2s_tx_core;
  import i2s_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] clk_div = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, i2s_sck, i2s_ws, i2s_sd, busy, underrun;

  i2s_tx_core dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clk_div  (clk_div),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .i2s_sck  (i2s_sck),
    .i2s_ws   (i2s_ws),
    .i2s_sd   (i2s_sd),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = !clk;

  int nvec = 0;
  int nerr = 0;

  // rise-edge capture of the serial line
  logic r_sd[$];
  logic r_ws[$];
  int   r_cyc[$];
  int   cyc = 0;
  int   ur_cyc = 0;
  int   ur_pulses = 0;
  logic prev_sck = 1'b0;
  logic prev_ur = 1'b0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (i2s_sck && !prev_sck) begin
      r_sd.push_back(i2s_sd);
      r_ws.push_back(i2s_ws);
      r_cyc.push_back(cyc);
    end
    prev_sck = i2s_sck;
    if (underrun) ur_cyc++;
    if (underrun && !prev_ur) ur_pulses++;
    prev_ur = underrun;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_cap();
    r_sd.delete();
    r_ws.delete();
    r_cyc.delete();
    ur_cyc = 0;
    ur_pulses = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_cap();
  endtask

  task automatic push(input logic [31:0] d);
    int t = 0;
    s_data = d;
    s_valid = 1'b1;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("push_timeout", 32'(t), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int t = 0;
    while (r_sd.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("rise_count", 32'(r_sd.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_pins", {29'b0, i2s_sck, i2s_ws, i2s_sd}, 32'd0);
  endtask

  function automatic logic [31:0] word_of(input int f);
    logic [31:0] w = '0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (f * FRAME_BITS + k < r_sd.size())
        w = {w[30:0], r_sd[f * FRAME_BITS + k]};
    end
    return w;
  endfunction

  function automatic int ws_bad(input int n);
    int bad = 0;
    for (int i = 0; i < n && i < r_ws.size(); i++) begin
      int k = i % FRAME_BITS;
      logic e = (k >= 15 && k <= 30);
      if (r_ws[i] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int per_bad(input int lo, input int hi, input int p);
    int bad = 0;
    for (int i = lo; i <= hi && i < r_cyc.size(); i++) begin
      if (r_cyc[i] - r_cyc[i-1] != p) bad++;
    end
    return bad;
  endfunction

  typedef struct {
    logic [15:0] div;
    logic [31:0] s0;
    logic [31:0] s1;
    int          n;
    logic [31:0] exp0;
    logic [31:0] exp1;
    int          exp_ur;
    int          exp_per;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{16'd1, 32'hA5A5_0F0F, 32'h0, 1, 32'hA5A5_0F0F, 32'h0, 1, 4};
    vt[1] = '{16'd1, 32'h1234_5678, 32'h9ABC_DEF0, 2,
              32'h1234_5678, 32'h9ABC_DEF0, 0, 4};
    vt[2] = '{16'd0, 32'hFFFF_0000, 32'h0001_0001, 2,
              32'hFFFF_0000, 32'h0001_0001, 0, 2};
    vt[3] = '{16'd2, 32'h8000_0001, 32'h0, 1, 32'h8000_0001, 32'h0, 1, 6};
    vt[4] = '{16'd5, 32'h7FFE_8001, 32'hC3C3_3C3C, 2,
              32'h7FFE_8001, 32'hC3C3_3C3C, 0, 12};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, s_ready}, 32'd1);
    chk("rst_pins", {28'b0, i2s_sck, i2s_ws, i2s_sd, underrun}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      clk_div = vt[v].div;
      enable = 1'b1;
      push(vt[v].s0);
      if (vt[v].n == 2) push(vt[v].s1);
      wait_rises(64, 64 * vt[v].exp_per + 200);
      enable = 1'b0;
      wait_idle(40 * vt[v].exp_per);
      chk($sformatf("v%0d_word0", v), word_of(0), vt[v].exp0);
      chk($sformatf("v%0d_word1", v), word_of(1), vt[v].exp1);
      chk($sformatf("v%0d_ws", v), 32'(ws_bad(64)), 32'd0);
      chk($sformatf("v%0d_period", v), 32'(per_bad(1, 63, vt[v].exp_per)),
          32'd0);
      chk($sformatf("v%0d_ur_clks", v), 32'(ur_cyc), 32'(vt[v].exp_ur));
      chk($sformatf("v%0d_ur_pulses", v), 32'(ur_pulses), 32'(vt[v].exp_ur));
    end

    // enable dropped mid-frame: frame still completes
    do_reset();
    clk_div = 16'd1;
    enable = 1'b1;
    push(32'hA5A5_0F0F);
    wait_rises(10, 200);
    enable = 1'b0;
    wait_idle(400);
    chk("abort_rises", 32'(r_sd.size()), 32'd32);
    chk("abort_word", word_of(0), 32'hA5A5_0F0F);
    chk("abort_ws", 32'(ws_bad(32)), 32'd0);
    chk("abort_ur", 32'(ur_cyc), 32'd0);

    // divider rewritten mid-frame takes effect on the next frame
    do_reset();
    clk_div = 16'd0;
    enable = 1'b1;
    push(32'hDEAD_BEEF);
    push(32'h0F1E_2D3C);
    wait_rises(5, 100);
    clk_div = 16'd3;
    wait_rises(64, 2000);
    enable = 1'b0;
    wait_idle(400);
    chk("div_per_f0", 32'(per_bad(1, 31, 2)), 32'd0);
    chk("div_gap", 32'(r_cyc[32] - r_cyc[31]), 32'd5);
    chk("div_per_f1", 32'(per_bad(33, 63, 8)), 32'd0);
    chk("div_word0", word_of(0), 32'hDEAD_BEEF);
    chk("div_word1", word_of(1), 32'h0F1E_2D3C);

    // asynchronous reset in slot 10
    do_reset();
    clk_div = 16'd1;
    enable = 1'b1;
    push(32'hFFFF_FFFF);
    wait_rises(11, 200);
    chk("pre_rst", {28'b0, i2s_sck, i2s_ws, i2s_sd, busy}, 32'hB);
    #1 reset = 1'b1;
    #1;
    chk("async_rst", {27'b0, i2s_sck, i2s_ws, i2s_sd, busy, underrun},
        32'd0);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, s_ready}, 32'd1);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // enable low: one accept, no SCK, then start on enable
    do_reset();
    begin
      int xfers = 0;
      s_data = 32'hC3C3_5A5A;
      s_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (s_ready) xfers++;
        @(negedge clk);
      end
      s_valid = 1'b0;
      chk("gated_xfers", 32'(xfers), 32'd1);
    end
    chk("gated_ready", {31'b0, s_ready}, 32'd0);
    chk("gated_rises", 32'(r_sd.size()), 32'd0);
    enable = 1'b1;
    @(posedge clk);
    #2;
    chk("start_lat", {30'b0, busy, i2s_sd}, 32'd3);
    @(negedge clk);
    enable = 1'b0;
    wait_idle(400);
    chk("gated_word", word_of(0), 32'hC3C3_5A5A);
    chk("gated_total", 32'(r_sd.size()), 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
